button_bounce_gen: RTL
======================

# button_bounce_gen

Synthesizable mechanical-button emulator: on a one-cycle `press` request it drives `button` through a contact-bounce burst, a clean held-high interval, a release-bounce burst and a quiet gap, then pulses `done`. It is the transmit side of the button path. It drives the button debouncer's input in on-board self-test and in simulation, so the click-counter display path is exercised without a physical switch.

## Interface
- `BOUNCE_CYCLES`, 4096: length of each bounce burst in cycles, >= 1.
- `HOLD_CYCLES`, 300000: clean high interval, >= 1; the default exceeds the debouncer's 250000-cycle threshold.
- `GAP_CYCLES`, 1000: clean low interval after release, >= 1.
- `TOGGLE_PERIOD`, 64: maximum cycles between bounce edges; power of two, >= 2.
- `LFSR_SEED`, 16'hACE1: initial LFSR state; a value of 0 is replaced by 16'hACE1.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `press`  in  1  press request, sampled only in IDLE.
- `button`  out  1  emulated raw switch level.
- `busy`  out  1  high from the accepted press until return to IDLE.
- `done`  out  1  one-cycle pulse on the first IDLE cycle after a sequence.

## Operation
- FSM states: IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
- Reset (async, also mid-sequence): state IDLE, `button`=0, `busy`=0, `done`=0, all counters 0, LFSR=seed.
- IDLE: `button`=0. If `press`=1, go to PRESS_BOUNCE. Otherwise stay.
- PRESS_BOUNCE:
  - On entry `button`=1 and the toggle timer is loaded.
  - When the timer reaches 0, `button` inverts and the timer reloads.
  - After BOUNCE_CYCLES cycles, go to HOLD.
- HOLD: `button` forced to 1 for HOLD_CYCLES cycles, then go to RELEASE_BOUNCE.
- RELEASE_BOUNCE: on entry `button`=0. Toggles as in PRESS_BOUNCE. After BOUNCE_CYCLES cycles, go to GAP.
- GAP: `button` forced to 0 for GAP_CYCLES cycles, then go to IDLE with `done`=1.
- Timer reload: TOGGLE_PERIOD-1 in the fixed mode, or the LFSR value in the random mode (see Configuration).
- `press` outside IDLE is ignored and not queued.
- `press` in the IDLE cycle where `done`=1 is accepted.
- Widths:
  - Phase counter is $clog2(max(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES)+1) bits.
  - Toggle timer is $clog2(TOGGLE_PERIOD) bits.
  - All counters decrement and never wrap.

## Timing
- All outputs are registered.
- `press` sampled high at edge t:
  - Edge t+1: PRESS_BOUNCE, `button`=1, `busy`=1.
  - HOLD begins at edge t+1+BOUNCE_CYCLES.
  - RELEASE_BOUNCE begins at edge t+1+BOUNCE_CYCLES+HOLD_CYCLES.
  - GAP begins at edge t+1+2*BOUNCE_CYCLES+HOLD_CYCLES.
  - IDLE begins at edge t+1+2*BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES, with `busy`=0 and `done`=1 for exactly one cycle.
- `busy` is high for exactly 2*BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles.
- Fixed mode: within a bounce burst, `button` holds each level for exactly TOGGLE_PERIOD cycles. The level in the final burst cycle is overridden by the next state.
- The LFSR advances every cycle while `busy`=1 and holds while in IDLE.

## Configuration
- Macro: `BUTTON_BOUNCE_LFSR_EN`.
- Defined:
  - The toggle timer reload is the low $clog2(TOGGLE_PERIOD) bits of a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Bounce intervals are therefore pseudo-random, 1..TOGGLE_PERIOD cycles.
  - The sequence is deterministic from reset.
- Undefined:
  - No LFSR is instantiated.
  - Reload is always TOGGLE_PERIOD-1, giving a fixed square-wave bounce.
  - LFSR_SEED is unused.

## Structure
- Package `btn_gen_pkg` holds:
  - the state enum;
  - LFSR tap mask 16'hB400;
  - default seed 16'hACE1.
- Sub-module `bounce_lfsr16`:
  - inputs clk, rst, enable;
  - 16-bit state output;
  - seed parameter;
  - instantiated only under BUTTON_BOUNCE_LFSR_EN.
- FSM, phase counter and toggle timer live in the top module.

## Test plan
- Reset mid-HOLD. Assert `rst` asynchronously between edges. Required: `button`/`busy`/`done` drop to 0 immediately. After release, a new `press` restarts the sequence from PRESS_BOUNCE.
- Fixed mode, BOUNCE_CYCLES=16, TOGGLE_PERIOD=4, HOLD_CYCLES=8, GAP_CYCLES=4; `press` at edge 0. Required `button`: 1111 0000 1111 0000, then 8×1, then 0000 1111 0000 1111, then 4×0. `done` high at edge 45. `busy` high for 44 cycles.
- `press` held high continuously. Required: back-to-back sequences, each re-accepted on its `done` cycle. No press lost or duplicated during `busy`.
- Single `press` pulses at edges 5 and 20 of one sequence. Required: ignored; exactly one `done`.
- LFSR mode, TOGGLE_PERIOD=64, seed 16'hACE1. Required:
  - every bounce interval is within 1..64 cycles;
  - the edge sequence is identical across two runs from reset;
  - `button`=1 throughout HOLD.
- Default parameters driving the debouncer. Required: exactly one `change` pulse per sequence, none during either bounce burst.

Source files
------------

// File: rtl/button_bounce_gen_pkg.sv
// Shared types and constants for the button bounce generator.
// State encoding, LFSR tap mask and the default LFSR seed.
package btn_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESS_BOUNCE   = 3'd1,
    ST_HOLD           = 3'd2,
    ST_RELEASE_BOUNCE = 3'd3,
    ST_GAP            = 3'd4
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bounce_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only while enabled.
// A zero seed would lock up, so it is replaced by the default seed.
module bounce_lfsr16
  import btn_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] state
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  logic [15:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_state <= INIT;
    else if (enable) r_state <= {r_state[14:0], ^(r_state & LFSR_TAPS)};
  end

  assign state = r_state;

endmodule

// File: rtl/button_bounce_gen.sv
// Mechanical button emulator: press bounce, clean hold, release bounce, quiet gap, then done.
// Define BUTTON_BOUNCE_LFSR_EN for pseudo-random bounce intervals; otherwise a fixed square wave.
module button_bounce_gen
  import btn_gen_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 4096,
  parameter int unsigned HOLD_CYCLES   = 300000,
  parameter int unsigned GAP_CYCLES    = 1000,
  parameter int unsigned TOGGLE_PERIOD = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic button,
  output logic busy,
  output logic done
);

  localparam int unsigned MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_C  = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);
  localparam int TW = $clog2(TOGGLE_PERIOD);

  localparam logic [CW-1:0] BOUNCE_LD = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmr;
  logic          r_button;
  logic          r_busy;
  logic          r_done;
  logic [TW-1:0] w_reload;

`ifdef BUTTON_BOUNCE_LFSR_EN
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  bounce_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .enable (r_busy),
    .state  (w_lfsr)
  );

  // Timer value v gives an interval of v+1 cycles, i.e. 1..TOGGLE_PERIOD.
  assign w_reload      = w_lfsr[TW-1:0];
  assign w_unused_lfsr = ^w_lfsr;
`else
  logic w_unused_seed;

  assign w_reload      = TW'(TOGGLE_PERIOD - 1);
  assign w_unused_seed = ^LFSR_SEED;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_button <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_button <= 1'b0;
          if (press) begin
            r_state  <= ST_PRESS_BOUNCE;
            r_busy   <= 1'b1;
            r_button <= 1'b1;
            r_cnt    <= BOUNCE_LD;
            r_tmr    <= w_reload;
          end
        end
        ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: begin
          if (r_cnt == '0) begin
            // Burst over: the next state's level overrides any pending toggle.
            if (r_state == ST_PRESS_BOUNCE) begin
              r_state  <= ST_HOLD;
              r_button <= 1'b1;
              r_cnt    <= HOLD_LD;
            end else begin
              r_state  <= ST_GAP;
              r_button <= 1'b0;
              r_cnt    <= GAP_LD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_tmr == '0) begin
              r_button <= ~r_button;
              r_tmr    <= w_reload;
            end else begin
              r_tmr <= r_tmr - 1'b1;
            end
          end
        end
        ST_HOLD: begin
          r_button <= 1'b1;
          if (r_cnt == '0) begin
            r_state  <= ST_RELEASE_BOUNCE;
            r_button <= 1'b0;
            r_cnt    <= BOUNCE_LD;
            r_tmr    <= w_reload;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          r_button <= 1'b0;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_button <= 1'b0;
        end
      endcase
    end
  end

  assign button = r_button;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
